sayac_demux1to8: RTL
====================

Name: sayac_demux1to8

Overview:
- Distribution counterpart of the SAYAC one-hot 8-to-1 data selector: routes one 16-bit source word to one of eight destination holding slots using the same 8-bit one-hot select encoding.
- sel bit 7 (MSB) selects d1; sel bit 0 selects d8.
- Each destination slot is a registered buffer with a valid/ack handshake. The producer side has a valid/ready handshake.
- An illegal select is rejected, flagged and counted.

Parameters:
- WIDTH, 16, data word width.
- NDEST, 8, number of destinations; equals the sel width. Fixed at 8 for SAYAC.
- ERRW, 8, width of the saturating illegal-select counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  source word.
- sel  input  NDEST  one-hot destination select; MSB = d1.
- in_valid  input  1  source offers din/sel this cycle.
- in_ready  output  1  combinational; the offered word is accepted this cycle.
- d1..d8  output  WIDTH each  slot holding registers.
- out_valid  output  NDEST  bit 7 = d1 … bit 0 = d8; slot holds an unconsumed word.
- out_ack  input  NDEST  consumer takes the word in the matching slot; same bit order.
- sel_err  output  1  registered one-cycle pulse on an illegal select offer.
- err_cnt  output  ERRW  saturating count of illegal select offers.

Behaviour:
- Reset (rst=1 at a clk edge):
  - d1..d8=0, out_valid=0, sel_err=0, err_cnt=0.
  - Any in-flight offer or ack in that cycle is discarded.
  - in_ready evaluates normally from the cleared state.
- Legal select: sel has exactly one bit set.
- Per-slot state machine with states EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on write.
  - FULL -> EMPTY on ack without a same-cycle write.
  - FULL -> FULL on write together with ack (pass-through).
- in_ready = legal(sel) AND the selected slot is (EMPTY OR its out_ack bit is 1 this cycle).
  - in_ready depends only on sel, out_valid and out_ack, never on in_valid.
- Write = in_valid AND in_ready.
  - At the next edge, the selected dN <= din and its out_valid bit <= 1.
  - Latency: 1 cycle from acceptance to out_valid/data visible.
- FULL slot not acked while selected: in_ready=0 and the source must hold din/sel. Other slots are unaffected.
- out_ack bit on an EMPTY slot is ignored.
- Acks on several slots in the same cycle are all honoured independently.
- An ack never alters dN; data holds its last written value after consumption.
- Illegal select (sel=0 or more than one bit set) together with in_valid=1:
  - No slot is written and in_ready=0.
  - sel_err=1 for exactly the next cycle.
  - err_cnt increments by 1, saturating at 2^ERRW-1 (255); no wrap.
- Illegal sel with in_valid=0: no effect, no error.
- If an illegal offer is held for N cycles, sel_err stays high for N cycles and err_cnt adds N (saturating).
- Write and ack on different slots in the same cycle: both take effect.

Decomposition:
- Package sayac_demux_pkg:
  - constants WIDTH_DEF=16, NDEST_DEF=8, ERRW_DEF=8;
  - one-hot select constants SEL_D1=8'b10000000 … SEL_D8=8'b00000001;
  - function is_onehot(sel).
- The same package is usable by the 8-to-1 selector.
- Sub-module sayac_demux_slot: one holding register plus valid flag, with inputs wr, ack, din.
  - Instantiated NDEST times by sayac_demux1to8.
- Select decode, in_ready and the error counter live in the top module.

Test Plan:
- Reset then single write: in_valid=1, sel=8'b00100000, din=16'hA5A5 -> in_ready=1. Next cycle d3=16'hA5A5 and out_valid=8'b00100000; all other outputs stay 0.
- Backpressure: slot d1 FULL, offer sel=8'b10000000, din=16'h1234, out_ack=0 -> in_ready=0 and d1 unchanged. Raise out_ack[7] -> in_ready=1 the same cycle; next cycle d1=16'h1234 and out_valid[7]=1 (pass-through).
- Illegal select: in_valid=1 with sel=8'b00000000 for 1 cycle, then sel=8'b11000000 for 2 cycles -> no slot written; sel_err high for 3 cycles; err_cnt=3.
- Saturation: 300 consecutive illegal offers -> err_cnt=255 and holds; sel_err stays 1 throughout.
- Concurrency: d8 FULL; in the same cycle write sel=8'b00000010, din=16'h00FF and out_ack=8'b00000001 -> next cycle out_valid=8'b00000010 and d7=16'h00FF.
- Reset mid-operation: slots d2 and d5 FULL, err_cnt=7; assert rst together with a legal write -> next cycle all outputs 0 and the write is lost.

Source files
------------

// File: rtl/sayac_demux_pkg.sv
// Shared SAYAC select-path definitions: default sizes, one-hot select codes,
// slot state encoding and the one-hot legality check.
package sayac_demux_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned NDEST_DEF = 8;
  localparam int unsigned ERRW_DEF  = 8;

  // MSB selects d1, LSB selects d8
  localparam logic [NDEST_DEF-1:0] SEL_D1 = 8'b1000_0000;
  localparam logic [NDEST_DEF-1:0] SEL_D2 = 8'b0100_0000;
  localparam logic [NDEST_DEF-1:0] SEL_D3 = 8'b0010_0000;
  localparam logic [NDEST_DEF-1:0] SEL_D4 = 8'b0001_0000;
  localparam logic [NDEST_DEF-1:0] SEL_D5 = 8'b0000_1000;
  localparam logic [NDEST_DEF-1:0] SEL_D6 = 8'b0000_0100;
  localparam logic [NDEST_DEF-1:0] SEL_D7 = 8'b0000_0010;
  localparam logic [NDEST_DEF-1:0] SEL_D8 = 8'b0000_0001;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic is_onehot(input logic [NDEST_DEF-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/sayac_demux_slot.sv
// One destination slot: holding register plus valid flag with write/ack control.
module sayac_demux_slot
  import sayac_demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             ack,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A write wins over an ack, so write+ack on a full slot passes through as FULL
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (wr) begin
      state_d = SLOT_FULL;
      data_d  = din;
    end else if (ack && state_q == SLOT_FULL) begin
      state_d = SLOT_EMPTY;
    end
  end

  assign dout  = data_q;
  assign valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/sayac_demux1to8.sv
// One-hot 1-to-8 distributor: routes din to the selected holding slot and
// rejects, flags and counts illegal select offers.
module sayac_demux1to8
  import sayac_demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NDEST = NDEST_DEF,
  parameter int unsigned ERRW  = ERRW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [NDEST-1:0] sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic [WIDTH-1:0] d5,
  output logic [WIDTH-1:0] d6,
  output logic [WIDTH-1:0] d7,
  output logic [WIDTH-1:0] d8,
  output logic [NDEST-1:0] out_valid,
  input  logic [NDEST-1:0] out_ack,
  output logic             sel_err,
  output logic [ERRW-1:0]  err_cnt
);

  logic             legal;
  logic             accept;
  logic             bad_offer;
  logic [NDEST-1:0] wr_vec;
  logic [WIDTH-1:0] slot_data [NDEST];

  logic             sel_err_q, sel_err_d;
  logic [ERRW-1:0]  err_cnt_q, err_cnt_d;

  assign legal     = is_onehot(sel);
  // Selected slot can take a word if empty or being drained this same cycle
  assign in_ready  = legal && ((sel & (~out_valid | out_ack)) != '0);
  assign accept    = in_valid && in_ready;
  assign wr_vec    = accept ? sel : '0;
  assign bad_offer = in_valid && !legal;

  for (genvar i = 0; i < NDEST; i++) begin : g_slot
    sayac_demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr_vec[i]),
      .ack   (out_ack[i]),
      .din   (din),
      .dout  (slot_data[i]),
      .valid (out_valid[i])
    );
  end

  assign d1 = slot_data[7];
  assign d2 = slot_data[6];
  assign d3 = slot_data[5];
  assign d4 = slot_data[4];
  assign d5 = slot_data[3];
  assign d6 = slot_data[2];
  assign d7 = slot_data[1];
  assign d8 = slot_data[0];

  always_comb begin
    sel_err_d = bad_offer;
    err_cnt_d = err_cnt_q;
    if (bad_offer && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + ERRW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      sel_err_q <= sel_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign sel_err = sel_err_q;
  assign err_cnt = err_cnt_q;

endmodule
